// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory
// requests, absorbs stalls in a one-entry skid buffer and handles redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_BUF
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_valid_q, out_valid_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            redirect_q  <= 32'h0;
            buf_pc_q    <= 32'h0;
            buf_inst_q  <= 32'h0;
            out_pc_q    <= 32'h0;
            out_inst_q  <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (branch_i) begin
                    pc_d        = branch_target_i;
                    out_valid_d = 1'b0;
                end
            end
            S_REQ: begin
                if (branch_i) begin
                    out_valid_d = 1'b0;
                    if (mem_ack_i) begin
                        pc_d = branch_target_i;
                    end else begin
                        redirect_d = branch_target_i;
                        state_d    = S_DRAIN;
                    end
                end else if (mem_ack_i) begin
                    pc_d = pc_q + 32'd4;
                    if (stall_i) begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = mem_data_i;
                        state_d    = S_BUF;
                    end else begin
                        out_pc_d    = pc_q;
                        out_inst_d  = mem_data_i;
                        out_valid_d = 1'b1;
                    end
                end else if (!stall_i) begin
                    out_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // The old request must complete before the redirect issues.
                out_valid_d = 1'b0;
                if (mem_ack_i) begin
                    pc_d    = branch_i ? branch_target_i : redirect_q;
                    state_d = S_REQ;
                end else if (branch_i) begin
                    redirect_d = branch_target_i;
                end
            end
            S_BUF: begin
                if (branch_i) begin
                    pc_d        = branch_target_i;
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else if (!stall_i) begin
                    out_pc_d    = buf_pc_q;
                    out_inst_d  = buf_inst_q;
                    out_valid_d = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_o  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign mem_addr_o = pc_q;
    assign if_pc_o    = out_pc_q;
    assign if_inst_o  = out_inst_q;
    assign if_valid_o = out_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic checked
// against a program-order model of the delivered instruction stream.
module tb_if_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    if_fetch dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o),
        .if_valid_o     (if_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    int          consumed = 0;
    int          lat = 0;
    int          wcnt = 0;
    bit          mode = 1'b0;
    bit          rnd = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr = 32'h0;
    logic [31:0] exp_pc = 32'h8000_0000;
    logic [31:0] prev_addr = 32'h0;
    bit          hold = 1'b0;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return mode ? (a ^ 32'h5A5A_5A5A) : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory responds, the consumed stream is scored, edge passes.
    task automatic tick();
        logic ack;
        ack = mem_req_o && (wcnt == lat);
        mem_ack_i = ack;
        mem_data_i = ack ? (ovr_en ? ovr : dfun(mem_addr_o)) : 32'h0;
        if (if_valid_o && !stall_i) begin
            chk("stream_pc", if_pc_o, exp_pc);
            chk("stream_inst", if_inst_o, dfun(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (branch_i) exp_pc = branch_target_i;
        if (mem_req_o && hold) chk("addr_hold", mem_addr_o, prev_addr);
        hold = mem_req_o && !ack;
        prev_addr = mem_addr_o;
        if (!mem_req_o || ack) wcnt = 0;
        else wcnt++;
        if (ack && rnd) lat = $urandom_range(0, 3);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);
        rst_i = 1'b1;
        tick();
        chk("first_req", {31'h0, mem_req_o}, 32'h1);
        chk("first_addr", mem_addr_o, 32'h8000_0000);
        tick();
        chk("zw_valid0", {31'h0, if_valid_o}, 32'h1);
        chk("zw_pc0", if_pc_o, 32'h8000_0000);
        chk("zw_addr1", mem_addr_o, 32'h8000_0004);
        tick();
        chk("zw_valid1", {31'h0, if_valid_o}, 32'h1);
        chk("zw_addr2", mem_addr_o, 32'h8000_0008);

        lat = 2;
        for (int k = 0; k < 3; k++) begin
            chk("lat_addr", mem_addr_o, 32'h8000_0008);
            tick();
            chk("lat_valid", {31'h0, if_valid_o}, (k == 2) ? 32'h1 : 32'h0);
        end
        chk("lat_pc0", if_pc_o, 32'h8000_0008);
        repeat (3) tick();
        chk("lat_pc1", if_pc_o, 32'h8000_000C);
        chk("lat_v1", {31'h0, if_valid_o}, 32'h1);

        lat = 1;
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_pc", if_pc_o, 32'h8000_000C);
            chk("stall_valid", {31'h0, if_valid_o}, 32'h1);
            if (k > 0) chk("buf_noreq", {31'h0, mem_req_o}, 32'h0);
        end
        stall_i = 1'b0;
        tick();
        chk("rel_pc", if_pc_o, 32'h8000_0010);
        chk("rel_valid", {31'h0, if_valid_o}, 32'h1);
        chk("rel_addr", mem_addr_o, 32'h8000_0014);
        chk("rel_req", {31'h0, mem_req_o}, 32'h1);

        lat = 0;
        repeat (3) tick();
        chk("pre_br_addr", mem_addr_o, 32'h8000_0020);
        lat = 2;
        ovr_en = 1'b1;
        ovr = 32'hDEAD_BEEF;
        branch_i = 1'b1;
        branch_target_i = 32'h8000_1000;
        tick();
        branch_i = 1'b0;
        chk("drain_valid", {31'h0, if_valid_o}, 32'h0);
        tick();
        chk("drain_addr", mem_addr_o, 32'h8000_0020);
        tick();
        chk("drop_valid", {31'h0, if_valid_o}, 32'h0);
        chk("redir_addr", mem_addr_o, 32'h8000_1000);
        ovr_en = 1'b0;
        lat = 0;
        tick();
        chk("tgt_pc", if_pc_o, 32'h8000_1000);

        branch_i = 1'b1;
        branch_target_i = 32'h8000_0100;
        tick();
        branch_i = 1'b0;
        chk("brack_valid", {31'h0, if_valid_o}, 32'h0);
        chk("brack_addr", mem_addr_o, 32'h8000_0100);
        tick();
        chk("brack_pc", if_pc_o, 32'h8000_0100);
        stall_i = 1'b1;
        tick();
        chk("bufb_req", {31'h0, mem_req_o}, 32'h0);
        branch_i = 1'b1;
        branch_target_i = 32'h8000_0200;
        tick();
        branch_i = 1'b0;
        stall_i = 1'b0;
        chk("bufb_valid", {31'h0, if_valid_o}, 32'h0);
        chk("bufb_addr", mem_addr_o, 32'h8000_0200);
        tick();
        chk("bufb_pc", if_pc_o, 32'h8000_0200);
        chk("bufb_v", {31'h0, if_valid_o}, 32'h1);

        lat = 3;
        #2;
        mem_ack_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("arst_req", {31'h0, mem_req_o}, 32'h0);
        chk("arst_valid", {31'h0, if_valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_pc = 32'h8000_0000;
        wcnt = 0;
        hold = 1'b0;
        lat = 0;
        mode = 1'b1;
        tick();
        chk("rs_addr", mem_addr_o, 32'h8000_0000);
        tick();
        chk("rs_pc", if_pc_o, 32'h8000_0000);

        rnd = 1'b1;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            branch_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)
                branch_target_i = 32'hFFFF_FFF8;
            else
                branch_target_i = {$urandom} & 32'hFFFF_FFFC;
            tick();
        end
        branch_i = 1'b0;
        stall_i = 1'b0;
        chk("progress", {31'h0, consumed > 300}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that produces the `{pc, inst}` pair consumed by the IF/ID pipeline register. It owns the program counter, issues single-outstanding requests to the instruction memory over a req/ack handshake, absorbs downstream stalls with a one-entry skid buffer, and redirects on branch/jump. Outputs are registered and drive the IF/ID register inputs directly.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: downstream cannot accept; outputs must hold.
- `branch_i` in 1: redirect request, valid for one cycle.
- `branch_target_i` in 32: redirect address, sampled when `branch_i`=1.
- `mem_req_o` out 1: instruction memory request.
- `mem_addr_o` out 32: request address; stable while `mem_req_o`=1 and no ack.
- `mem_ack_i` in 1: one-cycle acknowledge; `mem_data_i` valid same cycle.
- `mem_data_i` in 32: fetched instruction word.
- `if_pc_o` out 32: PC of presented instruction.
- `if_inst_o` out 32: presented instruction.
- `if_valid_o` out 1: presented pair is a real instruction (0 = bubble).

## Operation
- Registers: `pc_q` (address of current/next request), `redirect_q`, skid `buf_pc_q/buf_inst_q`, state, output regs. `mem_addr_o`=`pc_q`; `mem_req_o`=1 exactly in REQ and DRAIN.
- Edge priority: reset > branch > ack > stall.
- IDLE (reset state): no request. Next edge -> REQ; if `branch_i`, `pc_q`<=target first.
- REQ:
  - ack, no branch, `stall_i`=0: outputs<={`pc_q`, `mem_data_i`, 1}; `pc_q`+=4; stay REQ.
  - ack, no branch, `stall_i`=1: buf<={`pc_q`, data}; `pc_q`+=4; -> BUF; outputs hold.
  - ack with branch: data dropped; `pc_q`<=target; stay REQ; `if_valid_o`<=0.
  - no ack with branch: `redirect_q`<=target; -> DRAIN; `if_valid_o`<=0.
  - no ack, no branch: `if_valid_o`<=0 if `stall_i`=0, else outputs hold.
- DRAIN: request held at old address; `if_valid_o`<=0. Further `branch_i` overwrites `redirect_q`. On ack: data dropped, `pc_q`<=`redirect_q` (or `branch_target_i` if `branch_i` same edge), -> REQ.
- BUF: no request. `branch_i`: buffer dropped, `pc_q`<=target, `if_valid_o`<=0, -> REQ. Else `stall_i`=0: outputs<={buf, 1}, -> REQ. Else hold.
- Branch always clears `if_valid_o`, including during stall.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No alignment checking.
- Never more than one outstanding request; a dropped response never reaches outputs.

## Timing
- Reset (async assert): state IDLE, `pc_q`=`RESET_PC`, `if_pc_o`=0, `if_inst_o`=0, `if_valid_o`=0, buffers 0, `mem_req_o`=0 immediately (combinational from state). Deassert is synchronous-safe; first request visible the cycle after the first edge following release.
- Ack-to-output latency: 1 edge. Zero-wait memory (ack in request cycle) sustains 1 instruction/cycle.
- Branch-to-target request: next cycle if no request outstanding or ack coincides; otherwise after the outstanding ack.
- Stall release from BUF: buffered instruction valid on next edge; new request starts the cycle after.
- Reset mid-request: request abandoned; memory must tolerate `mem_req_o` dropping without ack.

## Test plan
- Reset then zero-wait memory returning addr as data: `mem_addr_o` = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; `if_valid_o`=1 every cycle from 2nd post-reset edge with `if_pc_o`=`if_inst_o`.
- 3-cycle-latency memory: `mem_addr_o` stable 3 cycles, `if_valid_o` 0,0,1 pattern; `if_pc_o` increments by 4 per delivered instruction.
- `stall_i`=1 for 4 cycles spanning an ack of 0x80000010: outputs frozen, `mem_req_o`=0 in BUF; after release `if_pc_o`=0x80000010 valid next edge, then request 0x80000014.
- `branch_i` with target 0x80001000 while request 0x80000020 outstanding, ack 2 cycles later with 0xDEADBEEF: 0xDEADBEEF never valid, next `mem_addr_o`=0x80001000.
- `branch_i` same cycle as ack (target 0x80000100): data dropped, `if_valid_o`=0, next request 0x80000100; also branch during BUF drops buffer.
- Async `rst_i` low mid-wait: `mem_req_o`, `if_valid_o` fall without clock edge; restart fetches 0x80000000.
